seq_det_param: RTL and testbench

Parametrised serial pattern detector. It succeeds the fixed 4-bit "1010" Moore detector.
- Pattern length is set by parameter; the pattern value is loadable at runtime.
- Overlapping or non-overlapping detection is selectable at runtime.
- Input is qualified by a valid strobe, so the source may stall.
- Outputs: a Moore-style registered match flag, a one-cycle match pulse, and a saturating match counter.
- Sits after a serial bit source (deserialiser or UART RX bit stream) and feeds control logic or a status register.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_param_if.sv | 33 +++
 rtl/seq_det_param_sat_counter.sv | 33 +++
 rtl/seq_det_param.sv | 86 ++++++++
 tb/tb_seq_det_param.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults, mode encodings and width helper for the parametrised
// serial pattern detector.
package seq_det_pkg;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1010;
    localparam int         DEF_CNT_W   = 8;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // fill counts 0..pat_len inclusive, so it needs one more code than pat_len
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// Bit-stream input, control and status bundle for seq_det_param.
interface seq_det_param_if
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
) ();
    localparam int FILL_W = fill_w(PAT_LEN);

    // Valid-only stream: x is consumed on every rising edge with in_valid=1;
    // there is no ready, the detector always accepts, the source may stall.
    logic               x;
    logic               in_valid;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               cnt_clr;
    logic               z;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_cnt;
    logic [FILL_W-1:0]  fill;

    modport master (
        output x, in_valid, overlap, pat_load, pat_in, cnt_clr,
        input  z, match_pulse, match_cnt, fill
    );

    modport slave (
        input  x, in_valid, overlap, pat_load, pat_in, cnt_clr,
        output z, match_pulse, match_cnt, fill
    );

endinterface

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with runtime pattern load,
// selectable overlap, valid-qualified input and a saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input logic            clk,
    input logic            rst,
    seq_det_param_if.slave bus
);
    localparam int FILL_W = fill_w(PAT_LEN);

    if ((PAT_LEN < 2) || (PAT_LEN > 32)) begin : g_bad_pat_len
        $error("seq_det_param: PAT_LEN must be in 2..32");
    end

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               z_q, z_d;
    logic               pulse_q, pulse_d;

    logic               accept;
    logic [PAT_LEN-1:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic               hit;

    assign accept = bus.in_valid && !bus.pat_load;
    assign hist_n = {hist_q[PAT_LEN-2:0], bus.x};
    assign fill_n = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
    // Requiring a full fill keeps stale history from before a reset or load out of any match
    assign hit    = accept && (fill_n == FILL_W'(PAT_LEN)) && (hist_n == pat_q);

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        z_d     = z_q;
        pulse_d = 1'b0;
        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            fill_d = '0;
            z_d    = 1'b0;
        end else if (bus.in_valid) begin
            hist_d  = hist_n;
            z_d     = hit;
            pulse_d = hit;
            fill_d  = (hit && (bus.overlap == MODE_NONOVL)) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            pulse_q <= pulse_d;
        end
    end

    logic [CNT_W-1:0] cnt;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (hit),
        .q   (cnt)
    );

    assign bus.z           = z_q;
    assign bus.match_pulse = pulse_q;
    assign bus.match_cnt   = cnt;
    assign bus.fill        = fill_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus a randomized run against
// a window-of-fresh-bits reference model.
module tb_seq_det_param;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // dut_a: default parameters; dut_b: narrow counter, all-ones pattern
    seq_det_param_if #(.PAT_LEN(4), .CNT_W(8)) ifa ();
    seq_det_param_if #(.PAT_LEN(4), .CNT_W(2)) ifb ();

    seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bits counted toward a match since the last reset, load
    // or non-overlapping hit, trimmed to the newest four.
    logic       m_bits[$];
    logic [3:0] m_pat;
    logic       m_z;
    logic       m_pulse;
    int         m_cnt;

    task automatic model_step(input logic r, input logic xv, input logic vv,
                              input logic ov, input logic pl,
                              input logic [3:0] pv, input logic cc);
        logic       hit;
        logic [3:0] win;
        hit = 1'b0;
        if (r) begin
            m_bits.delete();
            m_pat   = 4'b1010;
            m_z     = 1'b0;
            m_pulse = 1'b0;
            m_cnt   = 0;
        end else begin
            if (pl) begin
                m_pat = pv;
                m_bits.delete();
                m_z = 1'b0;
            end else if (vv) begin
                m_bits.push_back(xv);
                if (m_bits.size() > 4) void'(m_bits.pop_front());
                if (m_bits.size() == 4) begin
                    win = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
                    hit = (win == m_pat);
                end
                m_z = hit;
                if (hit && !ov) m_bits.delete();
            end
            m_pulse = hit;
            if (cc) m_cnt = 0;
            else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic drive_a(input logic xv, input logic vv, input logic ov,
                           input logic pl, input logic [3:0] pv, input logic cc);
        ifa.x        = xv;
        ifa.in_valid = vv;
        ifa.overlap  = ov;
        ifa.pat_load = pl;
        ifa.pat_in   = pv;
        ifa.cnt_clr  = cc;
        @(posedge clk);
        model_step(rst, xv, vv, ov, pl, pv, cc);
        #1;
    endtask

    task automatic drive_b(input logic xv, input logic vv, input logic cc);
        ifb.x        = xv;
        ifb.in_valid = vv;
        ifb.overlap  = 1'b1;
        ifb.cnt_clr  = cc;
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
        ifb.cnt_clr  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ifa.z !== 1'b0 || ifa.match_pulse !== 1'b0 || ifa.match_cnt !== 8'd0 || ifa.fill !== 3'd0) begin
            errors++;
            $display("FAIL reset_a: z=%b pulse=%b cnt=%0d fill=%0d, required all zero",
                     ifa.z, ifa.match_pulse, ifa.match_cnt, ifa.fill);
        end
        checks++;
        if (ifb.z !== 1'b0 || ifb.match_pulse !== 1'b0 || ifb.match_cnt !== 2'd0 || ifb.fill !== 3'd0) begin
            errors++;
            $display("FAIL reset_b: z=%b pulse=%b cnt=%0d fill=%0d, required all zero",
                     ifb.z, ifb.match_pulse, ifb.match_cnt, ifb.fill);
        end
    endtask

    task automatic test_overlap();
        logic bits[6]    = '{1, 0, 1, 0, 1, 0};
        logic exp_hit[6] = '{0, 0, 0, 1, 0, 1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_a(bits[i], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++;
            if (ifa.z !== exp_hit[i] || ifa.match_pulse !== exp_hit[i]) begin
                errors++;
                $display("FAIL overlap bit%0d: z=%b pulse=%b, required %b", i + 1,
                         ifa.z, ifa.match_pulse, exp_hit[i]);
            end
        end
        checks++;
        if (ifa.match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt: got %0d, required 2", ifa.match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic bits[6]    = '{1, 0, 1, 0, 1, 0};
        logic exp_hit[6] = '{0, 0, 0, 1, 0, 0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_a(bits[i], 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
            checks++;
            if (ifa.z !== exp_hit[i] || ifa.match_pulse !== exp_hit[i]) begin
                errors++;
                $display("FAIL nonoverlap bit%0d: z=%b pulse=%b, required %b", i + 1,
                         ifa.z, ifa.match_pulse, exp_hit[i]);
            end
        end
        checks++;
        if (ifa.fill !== 3'd2 || ifa.match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap_end: fill=%0d cnt=%0d, required fill=2 cnt=1",
                     ifa.fill, ifa.match_cnt);
        end
    endtask

    task automatic test_stall();
        logic bits[4] = '{1, 0, 1, 0};
        int   pulses;
        pulses = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_a(bits[i], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            if (ifa.match_pulse === 1'b1) pulses++;
            checks++;
            if (ifa.z !== (i == 3)) begin
                errors++;
                $display("FAIL stall_z bit%0d: got %b, required %b", i + 1, ifa.z, (i == 3));
            end
            if (i < 3) begin
                for (int k = 0; k < 3; k++) begin
                    drive_a(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
                    if (ifa.match_pulse === 1'b1) pulses++;
                    checks++;
                    if (ifa.z !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_idle_z bit%0d: got %b, required 0", i + 1, ifa.z);
                    end
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
            if (ifa.match_pulse === 1'b1) pulses++;
            checks++;
            if (ifa.z !== 1'b1 || ifa.match_pulse !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold idle%0d: z=%b pulse=%b, required z=1 pulse=0",
                         k, ifa.z, ifa.match_pulse);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL stall_pulse_count: got %0d, required 1", pulses);
        end
    endtask

    task automatic test_pat_load();
        logic bits[4]    = '{1, 1, 0, 1};
        logic exp_hit[4] = '{0, 0, 0, 1};
        apply_reset();
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
        checks++;
        if (ifa.z !== 1'b0 || ifa.fill !== 3'd0 || ifa.match_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle: z=%b fill=%0d pulse=%b, required 0/0/0",
                     ifa.z, ifa.fill, ifa.match_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(bits[i], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++;
            if (ifa.z !== exp_hit[i] || ifa.match_pulse !== exp_hit[i] || ifa.fill !== 3'(i + 1)) begin
                errors++;
                $display("FAIL load_post bit%0d: z=%b pulse=%b fill=%0d, required hit=%b fill=%0d",
                         i + 1, ifa.z, ifa.match_pulse, ifa.fill, exp_hit[i], i + 1);
            end
        end
        checks++;
        if (ifa.match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL load_cnt: got %0d, required 1", ifa.match_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_q[$];
        logic [1:0] exp_cnt;
        int         hits;
        int         pulses;
        hits   = 0;
        pulses = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i >= 3) hits++;
            exp_q.push_back((hits > 3) ? 2'd3 : 2'(hits));
        end
        for (int i = 0; i < 8; i++) begin
            drive_b(1'b1, 1'b1, 1'b0);
            if (ifb.match_pulse === 1'b1) pulses++;
            exp_cnt = exp_q.pop_front();
            checks++;
            if (ifb.match_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt bit%0d: got %0d, required %0d", i + 1, ifb.match_cnt, exp_cnt);
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL sat_hits: got %0d, required 5", pulses);
        end
        drive_b(1'b1, 1'b1, 1'b1);
        checks++;
        if (ifb.match_pulse !== 1'b1 || ifb.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL sat_clr_with_hit: pulse=%b cnt=%0d, required pulse=1 cnt=0",
                     ifb.match_pulse, ifb.match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        rst = 1'b1;
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (ifa.z !== 1'b0 || ifa.match_pulse !== 1'b0 || ifa.match_cnt !== 8'd0 || ifa.fill !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_during: z=%b pulse=%b cnt=%0d fill=%0d, required all zero",
                     ifa.z, ifa.match_pulse, ifa.match_cnt, ifa.fill);
        end
        rst = 1'b0;
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (ifa.z !== 1'b0 || ifa.fill !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_after: z=%b fill=%0d, required z=0 fill=1", ifa.z, ifa.fill);
        end
    endtask

    task automatic test_random();
        logic       xv, vv, ov, pl, cc;
        logic [3:0] pv;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            xv = 1'($urandom_range(0, 1));
            vv = ($urandom_range(0, 9) < 7);
            ov = (n < 200) ? 1'b1 : 1'($urandom_range(0, 1));
            pl = ($urandom_range(0, 49) == 0);
            pv = 4'($urandom_range(0, 15));
            cc = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 99) == 0);
            drive_a(xv, vv, ov, pl, pv, cc);
            rst = 1'b0;
            checks++;
            if (ifa.z !== m_z || ifa.match_pulse !== m_pulse ||
                ifa.match_cnt !== 8'(m_cnt) || ifa.fill !== 3'(m_bits.size())) begin
                errors++;
                $display("FAIL random cycle%0d: z=%b pulse=%b cnt=%0d fill=%0d, required z=%b pulse=%b cnt=%0d fill=%0d",
                         n, ifa.z, ifa.match_pulse, ifa.match_cnt, ifa.fill,
                         m_z, m_pulse, m_cnt, m_bits.size());
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        ifa.x = 1'b0; ifa.in_valid = 1'b0; ifa.overlap = 1'b1;
        ifa.pat_load = 1'b0; ifa.pat_in = 4'b0000; ifa.cnt_clr = 1'b0;
        ifb.x = 1'b0; ifb.in_valid = 1'b0; ifb.overlap = 1'b1;
        ifb.pat_load = 1'b0; ifb.pat_in = 4'b0000; ifb.cnt_clr = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_stall();
        test_pat_load();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
